// File: rtl/inport_tx_pkg.sv
// Package: inport_tx_pkg
// Shared definitions for the inport event transmitter:
//   - bit positions of the 32-bit event/status word presented to the host
//   - bit positions inside the host-written ack word
//   - event_t: the 24-bit payload stored per FIFO entry (bits [23:0] of the word)
//   - make_word(): assembles the host-visible word from head/seq/overflow
package inport_tx_pkg;

    // Host-visible word layout
    localparam int VALID_BIT = 31;
    localparam int SEQ_LSB   = 28;
    localparam int OVF_BIT   = 27;
    localparam int PRESS_BIT = 23;
    localparam int IDX_LSB   = 20;
    localparam int SNAP_LSB  = 16;
    localparam int TS_LSB    = 0;

    // Host-written ack word layout (sequence number lives in [2:0])
    localparam int ACK_EN_BIT  = 8;
    localparam int OVF_CLR_BIT = 9;

    // Field order matches word bits [23:0] exactly
    typedef struct packed {
        logic        press;
        logic [2:0]  idx;
        logic [3:0]  snap;
        logic [15:0] ts;
    } event_t;

    // Empty FIFO: payload and reserved fields read as zero
    function automatic logic [31:0] make_word(input logic       valid,
                                              input logic [2:0] seq,
                                              input logic       ovf,
                                              input event_t     ev);
        logic [31:0] w;
        w              = '0;
        w[VALID_BIT]   = valid;
        w[SEQ_LSB +: 3] = seq;
        w[OVF_BIT]     = ovf;
        if (valid) begin
            w[PRESS_BIT]     = ev.press;
            w[IDX_LSB +: 3]  = ev.idx;
            w[SNAP_LSB +: 4] = ev.snap;
            w[TS_LSB +: 16]  = ev.ts;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Module: button_debounce
// One push button: 2-FF synchroniser followed by a stability counter.
// The accepted level changes only after the synchronised input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles; any return to the accepted
// level restarts the count.
// Ports:
//   i_clk       in  1  clock
//   i_rst_n     in  1  asynchronous active-low reset (accepted level = released)
//   i_button_n  in  1  raw active-low button, asynchronous and bouncing
//   o_pressed   out 1  debounced level, 1 = pressed
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button_n,
    output logic o_pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    r_sync;     // r_sync[1] is the synchronised "pressed" level
    logic          r_pressed;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync    <= 2'b00;
            r_pressed <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync <= {r_sync[0], ~i_button_n};
            if (r_sync[1] == r_pressed) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_pressed <= r_sync[1];
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pressed = r_pressed;

endmodule

// File: rtl/inport_event_tx.sv
// Module: inport_event_tx
// FPGA-side transmitter for the host-polled inport PIO. Debounced button
// presses/releases become 32-bit event words queued in a small FIFO; the
// head is shown on inport_word and the host pops it by echoing the current
// sequence number through ack_word.
// Optional feature: define INPORT_TX_TIMESTAMP_EN to build the 16-bit tick
// counter (TICK_DIV clocks per tick) that stamps word bits [15:0]; otherwise
// those bits are zero and the TICK_DIV parameter does not exist.
// Ports:
//   clk_clk        in  1          clock (same domain as the PIO exports)
//   reset_reset_n  in  1          asynchronous active-low reset
//   buttons_n      in  N_BUTTONS  raw active-low keys
//   ack_word       in  32         [8] ack_en, [9] ovf_clr, [2:0] ack_seq
//   inport_word    out 32         registered FIFO head / status word
//   overflow       out 1          sticky dropped-event flag
//   fifo_level     out 4          entries queued, 0..FIFO_DEPTH
module inport_event_tx
    import inport_tx_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 8
`ifdef INPORT_TX_TIMESTAMP_EN
   ,parameter int TICK_DIV        = 50000
`endif
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [N_BUTTONS-1:0] buttons_n,
    input  logic [31:0]          ack_word,
    output logic [31:0]          inport_word,
    output logic                 overflow,
    output logic [3:0]           fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N_BUTTONS-1:0] w_db;
    logic [N_BUTTONS-1:0] r_reported;
    logic [N_BUTTONS-1:0] w_pending;
    logic [N_BUTTONS-1:0] w_win_oh;
    logic [2:0]           w_win_idx;
    logic                 w_has_evt;
    logic [15:0]          w_ts;
    event_t               w_event;
    event_t               w_head;

    logic [AW:0]  r_wr, r_rd, w_level;   // extra MSB distinguishes full from empty
    event_t       r_mem [FIFO_DEPTH];
    logic         w_empty, w_full, w_push, w_pop, w_drop;

    logic         r_ack_en, r_ack_clr, r_ack_clr_d;
    logic [2:0]   r_ack_seq;
    logic [2:0]   r_seq;
    logic         r_ovf;
    logic [31:0]  r_inport;

    logic         w_unused_ack;
    assign w_unused_ack = ^{ack_word[31:10], ack_word[7:3]};

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .i_clk      (clk_clk),
            .i_rst_n    (reset_reset_n),
            .i_button_n (buttons_n[gi]),
            .o_pressed  (w_db[gi])
        );
    end

`ifdef INPORT_TX_TIMESTAMP_EN
    localparam int TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [TDW-1:0] r_tick_div;
    logic [15:0]    r_ts;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_tick_div <= '0;
            r_ts       <= '0;
        end else if (r_tick_div == TDW'(TICK_DIV - 1)) begin
            r_tick_div <= '0;
            r_ts       <= r_ts + 16'd1;
        end else begin
            r_tick_div <= r_tick_div + 1'b1;
        end
    end
    assign w_ts = r_ts;
`else
    assign w_ts = 16'h0000;
`endif

    // Lowest pending index wins; others wait for later cycles
    assign w_pending = w_db ^ r_reported;
    always_comb begin
        w_has_evt = 1'b0;
        w_win_oh  = '0;
        w_win_idx = 3'd0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_has_evt   = 1'b1;
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_win_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        w_event.press = |(w_db & w_win_oh);
        w_event.idx   = w_win_idx;
        w_event.snap  = 4'(w_db);
        w_event.ts    = w_ts;
    end

    assign w_level = r_wr - r_rd;
    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_head  = r_mem[r_rd[AW-1:0]];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts then
    assign w_pop  = r_ack_en && (r_ack_seq == r_seq) && !w_empty;
    assign w_push = w_has_evt && (!w_full || w_pop);
    assign w_drop = w_has_evt && w_full && !w_pop;

    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= w_event;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ack_en    <= 1'b0;
            r_ack_clr   <= 1'b0;
            r_ack_clr_d <= 1'b0;
            r_ack_seq   <= 3'd0;
            r_reported  <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_seq       <= 3'd0;
            r_ovf       <= 1'b0;
            r_inport    <= '0;
        end else begin
            r_ack_en    <= ack_word[ACK_EN_BIT];
            r_ack_clr   <= ack_word[OVF_CLR_BIT];
            r_ack_seq   <= ack_word[2:0];
            r_ack_clr_d <= r_ack_clr;
            // Dropped events are still marked reported so they are not retried
            if (w_has_evt) begin
                r_reported <= r_reported ^ w_win_oh;
            end
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd  <= r_rd + 1'b1;
                r_seq <= r_seq + 3'd1;
            end
            // A drop outranks a simultaneous clear request
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (r_ack_clr && !r_ack_clr_d) begin
                r_ovf <= 1'b0;
            end
            r_inport <= make_word(!w_empty, r_seq, r_ovf, w_head);
        end
    end

    assign inport_word = r_inport;
    assign overflow    = r_ovf;
    assign fifo_level  = 4'(w_level);

endmodule

// File: tb/tb_inport_event_tx.sv
// Testbench for inport_event_tx. A queue-based reference model tracks the
// expected FIFO contents, sequence number and overflow flag from the event
// rules; DUT outputs are compared against it after each transaction.
module tb_inport_event_tx;

    localparam int NB   = 4;
    localparam int DEB  = 16;
    localparam int DEP  = 8;
    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  buttons_n;
    logic [31:0] ack_word;
    logic [31:0] inport_word;
    logic        overflow;
    logic [3:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t_rst    = 0;

    // Reference model state
    logic [23:0] exp_q[$];
    int          exp_tlo[$];
    int          exp_thi[$];
    logic [2:0]  exp_seq = 3'd0;
    logic        exp_ovf = 1'b0;
    logic [3:0]  btn_state = 4'b0000;   // 1 = pressed

    inport_event_tx #(
        .N_BUTTONS      (NB),
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (DEP)
`ifdef INPORT_TX_TIMESTAMP_EN
       ,.TICK_DIV       (TICK)
`endif
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .buttons_n    (buttons_n),
        .ack_word     (ack_word),
        .inport_word  (inport_word),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int rel_cyc();
        return cyc - t_rst;
    endfunction

    function automatic logic [31:0] exp_word();
        if (exp_q.size() == 0) return {1'b0, exp_seq, exp_ovf, 27'd0};
        return {1'b1, exp_seq, exp_ovf, 3'd0, exp_q[0]};
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] ew;
        ew = exp_word();
`ifdef INPORT_TX_TIMESTAMP_EN
        check({tag, ".word"}, inport_word & 32'hFFFF_0000, ew & 32'hFFFF_0000);
        if (exp_q.size() > 0)
            check({tag, ".ts"},
                  32'((int'(inport_word[15:0]) >= exp_tlo[0]) && (int'(inport_word[15:0]) <= exp_thi[0])),
                  32'd1);
`else
        check({tag, ".word"}, inport_word, ew);
`endif
        check({tag, ".level"}, 32'(fifo_level), 32'(exp_q.size()));
        check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        $display("%s: word=%08h level=%0d ovf=%0b seq=%0d", tag, inport_word, fifo_level, overflow, exp_seq);
    endtask

    // Every changed button yields one event, ascending index, snapshot = new state
    task automatic model_events(input logic [3:0] prev, input logic [3:0] nxt, input int c0);
        for (int i = 0; i < NB; i++) begin
            if (prev[i] != nxt[i]) begin
                if (exp_q.size() < DEP) begin
                    exp_q.push_back({nxt[i], 3'(i), nxt, 16'h0000});
                    exp_tlo.push_back(c0 / TICK - 1);
                    exp_thi.push_back((c0 + DEB + 12) / TICK + 1);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic button_step(input logic [3:0] nxt, input int nbounce);
        int c0;
        for (int b = 0; b < nbounce; b++) begin
            buttons_n = ~nxt;
            wait_cycles($urandom_range(1, DEB - 4));
            buttons_n = ~btn_state;
            wait_cycles($urandom_range(1, 3));
        end
        buttons_n = ~nxt;
        c0 = rel_cyc();
        wait_cycles(DEB + 12);
        model_events(btn_state, nxt, c0);
        btn_state = nxt;
    endtask

    task automatic random_step();
        logic [3:0] nxt;
        nxt = 4'($urandom_range(0, 15));
        if (nxt == btn_state) nxt[$urandom_range(0, 3)] = ~nxt[$urandom_range(0, 3)] ^ nxt[0] ^ nxt[0];
        if (nxt == btn_state) nxt = ~btn_state;
        button_step(nxt, int'($urandom_range(0, 3)));
    endtask

    task automatic do_ack(input logic [2:0] s, input logic en, input logic clr);
        ack_word = 32'(s) | (32'(en) << 8) | (32'(clr) << 9);
        wait_cycles(5);
        if (en && s == exp_seq && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(exp_tlo.pop_front());
            void'(exp_thi.pop_front());
            exp_seq = exp_seq + 3'd1;
        end
        if (clr) exp_ovf = 1'b0;
        ack_word = 32'd0;
        wait_cycles(3);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_tlo.delete();
        exp_thi.delete();
        exp_seq = 3'd0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        buttons_n = 4'hF;
        ack_word  = 32'd0;
        wait_cycles(3);
        rst_n = 1'b1;
        t_rst = cyc;

        // Idle after reset
        wait_cycles(5);
        check_outputs("reset_idle");

        // KEY0 press with bounces -> one event
        button_step(4'b0001, 3);
        check_outputs("key0_press");

        // Ack held for 100 cycles pops exactly once
        ack_word = 32'h100;
        wait_cycles(100);
        void'(exp_q.pop_front()); void'(exp_tlo.pop_front()); void'(exp_thi.pop_front());
        exp_seq = exp_seq + 3'd1;
        ack_word = 32'd0;
        wait_cycles(3);
        check_outputs("ack_held");
        check("empty_word_seq1", inport_word, 32'h1000_0000);

        // Two buttons in one cycle -> two events in index order
        button_step(4'b0111, 1);
        check_outputs("key12_press");
        button_step(4'b0001, 2);
        check_outputs("key12_release");
        do_ack(exp_seq + 3'd1, 1'b1, 1'b0);
        check_outputs("ack_wrong_seq");
        while (exp_q.size() > 0) begin
            do_ack(exp_seq, 1'b1, 1'b0);
            check_outputs("drain");
        end

        // Randomised mix of button activity and acks
        for (int k = 0; k < 30; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5)       random_step();
            else if (r < 8)  do_ack(exp_seq, 1'b1, 1'b0);
            else if (r == 8) do_ack(exp_seq + 3'd1, 1'b1, 1'b0);
            else             do_ack(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
            check_outputs($sformatf("rand%0d", k));
        end

        // Overflow: fill past depth, clear, then drain with seq wrap
        do_ack(exp_seq, 1'b0, 1'b1);
        for (int k = 0; k < 20 && !(exp_ovf && exp_q.size() == DEP); k++) begin
            random_step();
        end
        check_outputs("fifo_full");
        check("ovf_bit27", 32'(inport_word[27]), 32'd1);
        do_ack(exp_seq, 1'b0, 1'b1);
        check_outputs("ovf_clear");
        for (int k = 0; k < DEP; k++) begin
            do_ack(exp_seq, 1'b1, 1'b0);
            check_outputs($sformatf("pop%0d", k));
        end

        // Asynchronous reset mid-operation with events queued
        button_step(~btn_state, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst.word", inport_word, 32'd0);
        check("async_rst.level", 32'(fifo_level), 32'd0);
        check("async_rst.ovf", 32'(overflow), 32'd0);
        wait_cycles(3);
        rst_n = 1'b1;
        t_rst = cyc;
        // Buttons still held are reported afresh after reset
        wait_cycles(DEB + 12);
        model_events(4'b0000, btn_state, 0);
        check_outputs("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
